// File: rtl/aes_dec_key_prep.sv
// Turns the forward AES round-key schedule into the equivalent-inverse-cipher schedule and replays it
// in reverse. Define AES_DEC_KEY_PREP_REPLAY_EN to add the replay port that re-emits a kept schedule.
module aes_dec_key_prep #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort_i,
`ifdef AES_DEC_KEY_PREP_REPLAY_EN
  input  logic         replay_i,
`endif
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_key_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_key_o,
  output logic [3:0]   out_idx_o,
  output logic         out_last_o,
  output logic         busy_o
);

  if (NR > 15 || NR < 1) begin : gen_nr_illegal
    $error("aes_dec_key_prep: NR must be in 1..15");
  end

  localparam logic [3:0] LastIdx = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 of each column is its most significant byte.
  function automatic logic [31:0] imc_col(input logic [31:0] col);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a     = col[31-8*i -: 8];
      x2    = xtime(a);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] k);
    return {imc_col(k[127:96]), imc_col(k[95:64]), imc_col(k[63:32]), imc_col(k[31:0])};
  endfunction

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     idx_q, idx_d;
  logic           mem_we;
  logic [127:0]   mem_wdata;
  logic [127:0]   key_mem [NR+1];
  logic           replay_go;

`ifdef AES_DEC_KEY_PREP_REPLAY_EN
  logic kept_q, kept_d;
  assign replay_go = replay_i & kept_q;
`else
  assign replay_go = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    idx_d      = idx_q;
    mem_we     = 1'b0;
    mem_wdata  = (cnt_q == 4'd0 || cnt_q == LastIdx) ? in_key_i : inv_mix_columns(in_key_i);
`ifdef AES_DEC_KEY_PREP_REPLAY_EN
    kept_d     = kept_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (replay_go) begin
          state_d = StDrain;
          cnt_d   = LastIdx;
          key_d   = key_mem[NR];
          idx_d   = 4'd0;
        end else if (in_valid_i) begin
          state_d = StLoad;
          cnt_d   = 4'd0;
`ifdef AES_DEC_KEY_PREP_REPLAY_EN
          kept_d  = 1'b0;
`endif
        end
      end
      StLoad: begin
        if (in_valid_i) begin
          mem_we = 1'b1;
          if (cnt_q == LastIdx) begin
            // Stage dk[0] directly from the input so it is valid the cycle after the last write.
            state_d = StDrain;
            key_d   = mem_wdata;
            idx_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StDrain: begin
        if (out_ready_i) begin
          if (cnt_q == 4'd0) begin
            state_d = StIdle;
            key_d   = '0;
            idx_d   = 4'd0;
`ifdef AES_DEC_KEY_PREP_REPLAY_EN
            kept_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q - 4'd1;
            key_d = key_mem[cnt_q - 4'd1];
            idx_d = LastIdx - (cnt_q - 4'd1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort_i) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
      key_d   = '0;
      idx_d   = 4'd0;
      mem_we  = 1'b0;
`ifdef AES_DEC_KEY_PREP_REPLAY_EN
      kept_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      key_q   <= '0;
      idx_q   <= 4'd0;
`ifdef AES_DEC_KEY_PREP_REPLAY_EN
      kept_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
`ifdef AES_DEC_KEY_PREP_REPLAY_EN
      kept_q  <= kept_d;
`endif
    end
  end

  // Storage is never reset; validity is tracked by the FSM (and kept flag).
  always_ff @(posedge clk) begin
    if (mem_we) key_mem[cnt_q] <= mem_wdata;
  end

  assign in_ready_o  = (state_q == StLoad);
  assign out_valid_o = (state_q == StDrain);
  assign out_key_o   = key_q;
  assign out_idx_o   = idx_q;
  assign out_last_o  = out_valid_o && (idx_q == LastIdx);
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_aes_dec_key_prep.sv
// Randomized self-checking bench for aes_dec_key_prep against a GF(2^8) reference model.
// Exercises the replay feature when AES_DEC_KEY_PREP_REPLAY_EN is defined.
module tb_aes_dec_key_prep;
  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         abort = 1'b0;
  logic         replay = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_key;
  logic [3:0]   out_idx;
  logic         out_last;
  logic         busy;

  aes_dec_key_prep #(.NR(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .abort_i     (abort),
`ifdef AES_DEC_KEY_PREP_REPLAY_EN
    .replay_i    (replay),
`endif
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_key_i    (in_key),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_key_o   (out_key),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  logic [127:0] rk [0:NR];
  logic [7:0]   sb [0:255];
  logic [127:0] got_key [0:15];
  logic [3:0]   got_idx [0:15];
  logic         got_last [0:15];
  int n_got, stable_err, ready_err, last_err, drain_cyc, to_err;
  logic first_valid;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [127:0] imc_ref(input logic [127:0] k);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   o;
    int           mc [4];
    mc = '{14, 11, 13, 9};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) a[rr] = k[32*c+31-8*rr -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        o = 8'h00;
        for (int kk = 0; kk < 4; kk++) o = o ^ gmul(8'(mc[(kk - rr + 4) % 4]), a[kk]);
        r[32*c+31-8*rr -: 8] = o;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_dk(input int j);
    return (j == 0 || j == NR) ? rk[NR-j] : imc_ref(rk[NR-j]);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic random_keys();
    for (int i = 0; i <= NR; i++) rk[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic load(input int n, input int gap_max);
    int c;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_max == 0) ? 0 : $urandom_range(0, gap_max);
      in_valid = 1'b0;
      repeat (g) begin
        in_key = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_key   = rk[i];
      c = 0;
      @(negedge clk);
      while (!in_ready && c < 50) begin
        @(posedge clk); @(negedge clk); c++;
      end
      if (!in_ready) to_err++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain(input int n_max, input int stall_max);
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    logic         held;
    int           stall_left;
    n_got = 0; stable_err = 0; ready_err = 0; last_err = 0; drain_cyc = 0;
    held = 1'b0; stall_left = 0; prev_key = '0; prev_idx = '0;
    for (int i = 0; i < 16; i++) begin
      got_key[i] = '0; got_idx[i] = '0; got_last[i] = 1'b0;
    end
    while (n_got < n_max && drain_cyc < 500) begin
      if (stall_left > 0) begin
        out_ready = 1'b0; stall_left--;
      end else if (stall_max > 0 && $urandom_range(0, 2) == 0) begin
        out_ready = 1'b0; stall_left = $urandom_range(1, stall_max) - 1;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (drain_cyc == 0) first_valid = out_valid;
      if (!out_valid && out_last) last_err++;
      if (out_valid) begin
        if (in_ready) ready_err++;
        if (held && (out_key !== prev_key || out_idx !== prev_idx)) stable_err++;
        if (out_ready) begin
          got_key[n_got] = out_key; got_idx[n_got] = out_idx; got_last[n_got] = out_last;
          n_got++; held = 1'b0;
        end else begin
          held = 1'b1; prev_key = out_key; prev_idx = out_idx;
        end
      end
      @(posedge clk); #1;
      drain_cyc++;
    end
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_checks++;
    if ({out_valid, in_ready, out_last, busy} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {out_valid, in_ready, out_last, busy});
    else n_pass++;
    n_checks++;
    if (out_key !== 128'h0 || out_idx !== 4'h0)
      $display("FAIL reset_data: got key %h idx %0d want 0/0", out_key, out_idx);
    else n_pass++;
    #21 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_fips();
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    to_err = 0;
    @(posedge clk); #1;
    load(NR + 1, 0);
    drain(NR + 1, 0);
    n_checks++;
    if (first_valid !== 1'b1) $display("FAIL t1_latency: out_valid %b want 1", first_valid);
    else n_pass++;
    n_checks++;
    if (n_got !== NR + 1 || drain_cyc !== NR + 1 || to_err !== 0)
      $display("FAIL t1_count: got %0d in %0d cycles (to %0d) want %0d", n_got, drain_cyc, to_err,
               NR + 1);
    else n_pass++;
    n_checks++;
    if (got_key[0] !== 128'h13111d7fe3944a17f307a78b4d2b30c5)
      $display("FAIL t1_dk0: got %h want 13111d7fe3944a17f307a78b4d2b30c5", got_key[0]);
    else n_pass++;
    n_checks++;
    if (got_key[NR] !== 128'h000102030405060708090a0b0c0d0e0f)
      $display("FAIL t1_dk10: got %h want 000102030405060708090a0b0c0d0e0f", got_key[NR]);
    else n_pass++;
    for (int j = 0; j <= NR; j++) begin
      n_checks++;
      if (got_key[j] !== exp_dk(j) || got_idx[j] !== 4'(j) || got_last[j] !== (j == NR))
        $display("FAIL t1_dk[%0d]: got %h idx %0d last %b want %h idx %0d last %b", j, got_key[j],
                 got_idx[j], got_last[j], exp_dk(j), j, (j == NR));
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || last_err !== 0)
      $display("FAIL t1_idle: busy %b valid %b last_err %0d want 0 0 0", busy, out_valid, last_err);
    else n_pass++;
  endtask

  task automatic test_fixed_points();
    logic [127:0] pat [2];
    pat = '{{16{8'h5a}}, 128'h0};
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i <= NR; i++) rk[i] = pat[p];
      @(posedge clk); #1;
      load(NR + 1, 1);
      drain(NR + 1, 0);
      for (int j = 0; j <= NR; j++) begin
        n_checks++;
        if (got_key[j] !== pat[p])
          $display("FAIL t2_fixed[%0d][%0d]: got %h want %h", p, j, got_key[j], pat[p]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stalls();
    for (int rep = 0; rep < 3; rep++) begin
      random_keys();
      to_err = 0;
      @(posedge clk); #1;
      load(NR + 1, 3);
      drain(NR + 1, 5);
      n_checks++;
      if (stable_err !== 0 || ready_err !== 0 || to_err !== 0 || n_got !== NR + 1)
        $display("FAIL t3_hs[%0d]: stable_err %0d ready_err %0d to %0d n %0d want 0 0 0 %0d", rep,
                 stable_err, ready_err, to_err, n_got, NR + 1);
      else n_pass++;
      for (int j = 0; j <= NR; j++) begin
        n_checks++;
        if (got_key[j] !== exp_dk(j) || got_idx[j] !== 4'(j) || got_last[j] !== (j == NR))
          $display("FAIL t3_dk[%0d][%0d]: got %h idx %0d want %h idx %0d", rep, j, got_key[j],
                   got_idx[j], exp_dk(j), j);
        else n_pass++;
      end
    end
  endtask

  task automatic test_abort();
    random_keys();
    @(posedge clk); #1;
    load(4, 1);
    in_valid = 1'b1;
    in_key   = rk[4];
    abort    = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL t4_abort_load: busy %b in_ready %b want 0 0", busy, in_ready);
    else n_pass++;
    random_keys();
    @(posedge clk); #1;
    load(NR + 1, 2);
    drain(NR + 1, 2);
    for (int j = 0; j <= NR; j++) begin
      n_checks++;
      if (got_key[j] !== exp_dk(j))
        $display("FAIL t4_fresh[%0d]: got %h want %h", j, got_key[j], exp_dk(j));
      else n_pass++;
    end
    random_keys();
    load(NR + 1, 0);
    drain(3, 0);
    abort     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL t4_pre_abort_valid: got %b want 1", out_valid);
    else n_pass++;
    @(posedge clk); #1;
    abort     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0)
      $display("FAIL t4_abort_drain: valid %b busy %b last %b want 0 0 0", out_valid, busy,
               out_last);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    random_keys();
    @(posedge clk); #1;
    load(NR + 1, 0);
    drain(4, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, out_last, busy} !== 4'b0 || out_key !== 128'h0 || out_idx !== 4'h0)
      $display("FAIL t5_async: flags %b key %h idx %0d want 0000 0 0",
               {out_valid, in_ready, out_last, busy}, out_key, out_idx);
    else n_pass++;
    #4 rst_n = 1'b1;
    random_keys();
    @(posedge clk); #1;
    load(NR + 1, 1);
    drain(NR + 1, 3);
    for (int j = 0; j <= NR; j++) begin
      n_checks++;
      if (got_key[j] !== exp_dk(j) || got_idx[j] !== 4'(j))
        $display("FAIL t5_reload[%0d]: got %h idx %0d want %h idx %0d", j, got_key[j], got_idx[j],
                 exp_dk(j), j);
      else n_pass++;
    end
  endtask

`ifdef AES_DEC_KEY_PREP_REPLAY_EN
  task automatic test_replay();
    random_keys();
    @(posedge clk); #1;
    load(NR + 1, 1);
    drain(NR + 1, 2);
    @(posedge clk); #1;
    replay = 1'b1;
    @(posedge clk); #1;
    replay = 1'b0;
    drain(NR + 1, 2);
    for (int j = 0; j <= NR; j++) begin
      n_checks++;
      if (got_key[j] !== exp_dk(j) || got_idx[j] !== 4'(j) || got_last[j] !== (j == NR))
        $display("FAIL t6_replay[%0d]: got %h idx %0d want %h idx %0d", j, got_key[j], got_idx[j],
                 exp_dk(j), j);
      else n_pass++;
    end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort  = 1'b0;
    replay = 1'b1;
    @(posedge clk); #1;
    replay = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL t6_replay_after_abort: busy %b valid %b want 0 0", busy, out_valid);
    else n_pass++;
  endtask
`endif

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_fixed_points();
    test_stalls();
    test_abort();
    test_async_reset();
`ifdef AES_DEC_KEY_PREP_REPLAY_EN
    test_replay();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
